data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Multi-cycle responder for the core's data-memory interface. It replaces the single-cycle data memory with a valid/ready request/response handshake, a configurable wait-state count, and RV32 byte/half/word access with load sign/zero extension. It sits between the core's load/store path and a byte-addressed word array that the block owns internally.

Parameters:
DATA_WIDTH, 32, data bus width; fixed at 32 (four byte lanes), any other value is an elaboration error
ADDR_WIDTH, 5, byte-address width; storage is 2**(ADDR_WIDTH-2) words
LATENCY, 2, number of wait cycles between accept and response; 0..15 legal

Ports:
clk_i  in  1  clock
reset_ni  in  1  synchronous, active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  responder can accept a request
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  access size/sign, RV32 load/store funct3 encoding
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-aligned
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core accepts the response
rsp_rdata_o  out  DATA_WIDTH  load result, extended; 0 for stores and errors
rsp_err_o  out  1  misaligned access or illegal funct3

Behaviour:
- Clock/reset: one clock, clk_i. Reset is synchronous and active-low on reset_ni.
- Reset values: state = IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, wait counter = 0. Memory contents are not reset.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready_o = 1. When req_valid_i && req_ready_o, capture we, funct3, addr and wdata.
    - If LATENCY > 0: go to WAIT and load the counter with LATENCY-1.
    - If LATENCY = 0: go directly to RESP.
  - WAIT: req_ready_o = 0. Decrement the counter each cycle. When the counter is 0, go to RESP.
  - RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are stable and held until rsp_ready_i. On rsp_valid_o && rsp_ready_i, go to IDLE. The next request can be accepted no earlier than the following cycle; there is no accept in the same cycle as a response handshake.
- Latency: rsp_valid_o rises exactly LATENCY+1 cycles after the accept edge.
- Commit point: store commits and load-data capture happen on the edge that enters RESP. Memory is read and written only at that edge.
- Access sizes (funct3 value → access):
  - 000 → B (signed for loads)
  - 001 → H (signed for loads)
  - 010 → W
  - 100 → BU (loads only)
  - 101 → HU (loads only)
  - Any other value, including 100/101 on a store, is illegal and sets rsp_err_o.
- Alignment rules:
  - H/HU requires addr[0] = 0.
  - W requires addr[1:0] = 00.
  - Violations are errors (subject to the Optional Feature).
- Stores:
  - Byte lane = addr[1:0].
  - SB writes wdata[7:0] into that lane.
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes the full word.
  - Untouched lanes are preserved.
  - An errored store writes nothing.
- Loads: select the lane(s) by addr[1:0], right-align, then sign- or zero-extend to 32 bits. An errored load returns 0.
- Word index = addr[ADDR_WIDTH-1:2]. No wrap-around beyond the array; the address width bounds it.
- Reset mid-operation: an in-flight request is dropped and no store commits. If reset is asserted on the commit edge, reset wins and memory is unchanged.
- Inputs are ignored outside the accept cycle.

Optional Feature:
Macro: DMEM_MISALIGN_ERR_EN
- Defined: misaligned accesses set rsp_err_o as described above (no write; load data = 0).
- Undefined: misalignment is never an error.
  - Address low bits are forced to alignment (H clears addr[0]; W clears addr[1:0]).
  - The access proceeds normally.
  - rsp_err_o is asserted only for an illegal funct3.

Decomposition:
- dmem_pkg: state enum (IDLE/WAIT/RESP); funct3 constants MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU; LATENCY counter width constant (4).
- One sub-module, dmem_lane_align: purely combinational. It produces the store byte-enable and lane-shifted write data, and extracts/extends load data from the word plus addr[1:0] plus funct3. The responder owns the FSM, counter and storage.

Test Plan:
- Reset: hold reset_ni = 0 for 3 cycles → req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
- Word round-trip (LATENCY = 2): SW addr 0x04 data 0xDEADBEEF, then LW 0x04 → rsp_valid_o exactly 3 cycles after each accept; rdata = 0xDEADBEEF, err = 0.
- Sub-word:
  - after SW 0x08 = 0x11223344, SB 0x09 = 0xA5; LW 0x08 → 0x1122A544;
  - LB 0x09 → 0xFFFFFFA5; LBU 0x09 → 0x000000A5;
  - LH 0x0A → 0x00001122.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles in RESP → rsp_valid_o and rdata stay stable and req_ready_o = 0; the cycle after rsp_ready_i = 1, req_ready_o = 1.
- Errors with DMEM_MISALIGN_ERR_EN:
  - LW 0x06 → err = 1, rdata = 0;
  - SH 0x03 → err = 1, memory unchanged;
  - store with funct3 = 100 → err = 1.
  - Without the macro: LW 0x06 returns the word at 0x04 with err = 0.
- Reset mid-flight and LATENCY = 0:
  - accept SW 0x10 = 0x55, assert reset in WAIT, then LW 0x10 → prior contents returned;
  - with LATENCY = 0, rsp_valid_o rises 1 cycle after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the FSM state, the RV32 load/store funct3 codes and the wait-counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses: store byte enables, lane-replicated
// write data, load extract/extend and error detection. Honours DMEM_MISALIGN_ERR_EN.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic        illegal;
    logic        misalign;
    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        illegal  = 1'b1;
        misalign = 1'b0;
        off      = offset_i;
        case (funct3_i)
            MEM_B:  illegal = 1'b0;
            MEM_BU: illegal = we_i;
            MEM_H: begin
                illegal  = 1'b0;
                misalign = offset_i[0];
            end
            MEM_HU: begin
                illegal  = we_i;
                misalign = offset_i[0];
            end
            MEM_W: begin
                illegal  = 1'b0;
                misalign = (offset_i != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

`ifdef DMEM_MISALIGN_ERR_EN
        err_o = illegal | misalign;
`else
        err_o = illegal;
        // Misaligned accesses silently snap down to their natural alignment.
        if (misalign) begin
            off = funct3_i[1] ? 2'b00 : {offset_i[1], 1'b0};
        end
`endif

        shifted      = rword_i >> {off, 3'b000};
        byte_en_o    = 4'b0000;
        wdata_lane_o = 32'h0;
        rdata_o      = 32'h0;

        if (!err_o) begin
            if (we_i) begin
                case (funct3_i[1:0])
                    2'b00: begin
                        byte_en_o    = 4'b0001 << off;
                        wdata_lane_o = {4{wdata_i[7:0]}};
                    end
                    2'b01: begin
                        byte_en_o    = off[1] ? 4'b1100 : 4'b0011;
                        wdata_lane_o = {2{wdata_i[15:0]}};
                    end
                    default: begin
                        byte_en_o    = 4'b1111;
                        wdata_lane_o = wdata_i;
                    end
                endcase
            end else begin
                case (funct3_i)
                    MEM_B:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
                    MEM_BU:  rdata_o = {24'h0, shifted[7:0]};
                    MEM_H:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
                    MEM_HU:  rdata_o = {16'h0, shifted[15:0]};
                    default: rdata_o = rword_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with valid/ready handshakes and LATENCY wait states.
// Define DMEM_MISALIGN_ERR_EN to report misaligned accesses as errors instead of aligning them.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);
    localparam logic [CntWidth-1:0] CntLoad =
        (LATENCY > 0) ? CntWidth'(LATENCY - 1) : '0;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_mem_responder: DATA_WIDTH must be 32");
    end
    if (LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be 0..15");
    end

    dmem_state_e           state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [Words];

    logic                  accept;
    logic                  commit;
    logic                  cur_we;
    logic [2:0]            cur_funct3;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [DATA_WIDTH-1:0] rword;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  access_err;

    assign accept = req_valid_i && req_ready_o;
    // With zero wait states the commit happens on the accept edge, so use the live request.
    assign commit = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == '0));

    always_comb begin
        if (state_q == IDLE) begin
            cur_we     = req_we_i;
            cur_funct3 = req_funct3_i;
            cur_addr   = req_addr_i;
            cur_wdata  = req_wdata_i;
        end else begin
            cur_we     = we_q;
            cur_funct3 = funct3_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
    end

    assign word_idx = cur_addr[ADDR_WIDTH-1:2];
    assign rword    = mem[word_idx];

    dmem_lane_align u_lane_align (
        .we_i         (cur_we),
        .funct3_i     (cur_funct3),
        .offset_i     (cur_addr[1:0]),
        .wdata_i      (cur_wdata),
        .rword_i      (rword),
        .byte_en_o    (byte_en),
        .wdata_lane_o (wdata_lane),
        .rdata_o      (load_data),
        .err_o        (access_err)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= load_data;
                            rsp_err_o   <= access_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CntLoad;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                        rsp_err_o   <= access_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; a reset coinciding with the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (reset_ni && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model plus directed vectors, LATENCY 2 and 0.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_ready, a_we = 1'b0, a_rsp_valid, a_rsp_ready = 1'b0;
    logic [2:0]  a_f3 = 3'b000;
    logic [4:0]  a_addr = 5'h0;
    logic [31:0] a_wdata = 32'h0, a_rdata;
    logic        a_err;

    logic        b_req_valid = 1'b0, b_req_ready, b_we = 1'b0, b_rsp_valid, b_rsp_ready = 1'b0;
    logic [2:0]  b_f3 = 3'b000;
    logic [4:0]  b_addr = 5'h0;
    logic [31:0] b_wdata = 32'h0, b_rdata;
    logic        b_err;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LATENCY(2)) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_we),
        .req_funct3_i(a_f3), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rdata), .rsp_err_o(a_err)
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LATENCY(0)) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
        .req_funct3_i(b_f3), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rdata), .rsp_err_o(b_err)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain byte array, RV32 rules applied directly.
    logic [7:0]  mb [32];
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    task automatic model(input logic we, input logic [2:0] f3, input logic [4:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int size;
        int a;
        logic illegal;
        logic mis;
        a = int'(addr);
        illegal = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                    (!we && ((f3 == 3'd4) || (f3 == 3'd5))));
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = (a % size) != 0;
`ifdef DMEM_MISALIGN_ERR_EN
        err = illegal || mis;
`else
        err = illegal;
        a = a - (a % size);
`endif
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) mb[a + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) rd[8*k +: 8] = mb[a + k];
                if (f3[2] == 1'b0 && size == 1 && rd[7]) rd = rd | 32'hFFFF_FF00;
                if (f3[2] == 1'b0 && size == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
            end
        end
    endtask

    // Checks every cycle the response is presented (includes backpressure hold cycles).
    always @(negedge clk) begin
        if (rst_n && a_rsp_valid) begin
            check("model_rdata", a_rdata, exp_rdata);
            check("model_err", {31'b0, a_err}, {31'b0, exp_err});
            check("ready_low_in_resp", {31'b0, a_req_ready}, 32'd0);
        end
    end

    task automatic a_req(input logic we, input logic [2:0] f3, input logic [4:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic err);
        int cyc;
        logic [31:0] first_rd;
        check("a_ready_idle", {31'b0, a_req_ready}, 32'd1);
        model(we, f3, addr, wd, exp_err, exp_rdata);
        a_req_valid = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wd;
        @(negedge clk);
        // Garbage outside the accept cycle must be ignored.
        a_req_valid = 1'b0; a_we = ~we; a_f3 = 3'b111; a_addr = addr ^ 5'h1f; a_wdata = ~wd;
        cyc = 1;
        while (!a_rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("a_latency", 32'(cyc), 32'd3);
        rd = a_rdata;
        err = a_err;
        first_rd = a_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, a_rsp_valid}, 32'd1);
            check("bp_ready", {31'b0, a_req_ready}, 32'd0);
        end
        if (hold > 0) check("bp_stable", a_rdata, first_rd);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check("a_valid_after_hs", {31'b0, a_rsp_valid}, 32'd0);
        check("a_ready_after_hs", {31'b0, a_req_ready}, 32'd1);
    endtask

    task automatic b_req(input logic we, input logic [2:0] f3, input logic [4:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
        int cyc;
        b_req_valid = 1'b1; b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wd;
        @(negedge clk);
        b_req_valid = 1'b0;
        cyc = 1;
        while (!b_rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b_latency", 32'(cyc), 32'd1);
        check("b_err", {31'b0, b_err}, 32'd0);
        rd = b_rdata;
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        check("b_ready_after_hs", {31'b0, b_req_ready}, 32'd1);
    endtask

    // Accept a store, then pull reset after wait_edges further edges; the store must not land.
    task automatic a_abort(input logic [4:0] addr, input logic [31:0] wd, input int wait_edges);
        a_req_valid = 1'b1; a_we = 1'b1; a_f3 = 3'b010; a_addr = addr; a_wdata = wd;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("abort_accepted", {31'b0, a_req_ready}, 32'd0);
        repeat (wait_edges) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst_ready", {31'b0, a_req_ready}, 32'd1);
        check("abort_rst_valid", {31'b0, a_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        for (int i = 0; i < 32; i++) mb[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", {31'b0, a_err}, 32'd0);
        check("rst_b_ready", {31'b0, b_req_ready}, 32'd1);
        check("rst_b_valid", {31'b0, b_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        a_req(1'b1, 3'b010, 5'h04, 32'hDEADBEEF, 0, rd, er);
        check("sw_rdata_zero", rd, 32'h0);
        a_req(1'b0, 3'b010, 5'h04, 32'h0, 0, rd, er);
        check("lw04", rd, 32'hDEADBEEF);
        check("lw04_err", {31'b0, er}, 32'd0);

        a_req(1'b1, 3'b010, 5'h08, 32'h11223344, 0, rd, er);
        a_req(1'b1, 3'b000, 5'h09, 32'hFFFFFFA5, 0, rd, er);
        a_req(1'b0, 3'b010, 5'h08, 32'h0, 0, rd, er);
        check("lw08_after_sb", rd, 32'h1122A544);
        a_req(1'b0, 3'b000, 5'h09, 32'h0, 0, rd, er);
        check("lb09", rd, 32'hFFFFFFA5);
        a_req(1'b0, 3'b100, 5'h09, 32'h0, 0, rd, er);
        check("lbu09", rd, 32'h000000A5);
        a_req(1'b0, 3'b001, 5'h0A, 32'h0, 0, rd, er);
        check("lh0a", rd, 32'h00001122);
        a_req(1'b0, 3'b001, 5'h08, 32'h0, 0, rd, er);
        check("lh08_neg", rd, 32'hFFFFA544);

        a_req(1'b0, 3'b010, 5'h08, 32'h0, 5, rd, er);
        check("bp_lw08", rd, 32'h1122A544);

        a_req(1'b0, 3'b010, 5'h06, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check("lw06_err", {31'b0, er}, 32'd1);
        check("lw06_rdata", rd, 32'h0);
`else
        check("lw06_err", {31'b0, er}, 32'd0);
        check("lw06_rdata", rd, 32'hDEADBEEF);
`endif

        a_req(1'b1, 3'b010, 5'h00, 32'h01020304, 0, rd, er);
        a_req(1'b1, 3'b001, 5'h03, 32'h0000BEEF, 0, rd, er);
        a_req(1'b0, 3'b010, 5'h00, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check("sh03_unchanged", rd, 32'h01020304);
`else
        check("sh03_aligned", rd, 32'hBEEF0304);
`endif

        a_req(1'b1, 3'b100, 5'h08, 32'hFFFFFFFF, 0, rd, er);
        check("sbu_illegal_err", {31'b0, er}, 32'd1);
        a_req(1'b0, 3'b010, 5'h08, 32'h0, 0, rd, er);
        check("illegal_no_write", rd, 32'h1122A544);

        a_req(1'b1, 3'b010, 5'h10, 32'hCAFEF00D, 0, rd, er);
        a_req(1'b1, 3'b010, 5'h14, 32'h0BADF00D, 0, rd, er);
        a_abort(5'h10, 32'h00000055, 0);
        a_abort(5'h14, 32'h00000055, 1);
        a_req(1'b0, 3'b010, 5'h10, 32'h0, 0, rd, er);
        check("abort_wait_mem", rd, 32'hCAFEF00D);
        a_req(1'b0, 3'b010, 5'h14, 32'h0, 0, rd, er);
        check("abort_commit_mem", rd, 32'h0BADF00D);

        b_req(1'b1, 3'b010, 5'h04, 32'h12345678, rd);
        b_req(1'b0, 3'b010, 5'h04, 32'h0, rd);
        check("b_lw04", rd, 32'h12345678);
        b_req(1'b0, 3'b101, 5'h06, 32'h0, rd);
        check("b_lhu06", rd, 32'h00001234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
